// File: rtl/ternary_match_pkg.sv
// Shared types, mode constants and default table contents
// for the ternary match scanner.
package ternary_match_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        LOOP,
        END
    } state_t;

    localparam int MODE_OR    = 0;
    localparam int MODE_FIRST = 1;
    localparam int MODE_COUNT = 2;

    localparam int ENTRY_MAX = 256;

    // Legacy 8x20-bit table only applies to the original geometry.
    function automatic logic [ENTRY_MAX-1:0] default_entry(
        input int k,
        input int data_w,
        input int out_w,
        input int depth
    );
        logic [19:0] w_e;
        case (k)
            0:       w_e = 20'h7F97A;
            1:       w_e = 20'h39D62;
            2:       w_e = 20'hA8FFF;
            3:       w_e = 20'hFF6BA;
            4:       w_e = 20'hFFF6E;
            5:       w_e = 20'hFFBA8;
            6:       w_e = 20'hCA75B;
            7:       w_e = 20'h2FFF4;
            default: w_e = '0;
        endcase
        if (data_w != 8 || out_w != 4 || depth != 8) begin
            w_e = '0;
        end
        return ENTRY_MAX'(w_e);
    endfunction

endpackage

// File: rtl/ternary_match_scanner_table.sv
// Ternary entry register file: async reset to defaults,
// one write port, one combinational read port.
module ternary_match_table
    import ternary_match_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int OUT_W  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int EW    = 2*DATA_W + OUT_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [EW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [EW-1:0] o_rdata
);

    logic [EW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= EW'(default_entry(k, DATA_W, OUT_W, DEPTH));
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ternary_match_scanner.sv
// Scans a ternary table against a captured input word and
// publishes an OR / first-match / count result per run.
module ternary_match_scanner
    import ternary_match_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int OUT_W  = 4,
    parameter int MODE   = 0,
    localparam int AW    = $clog2(DEPTH),
    localparam int EW    = 2*DATA_W + OUT_W
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] I,
    input  logic              WE,
    input  logic [AW-1:0]     WADDR,
    input  logic [EW-1:0]     WDATA,
    output logic [OUT_W-1:0]  O,
    output logic              BUSY,
    output logic              DONE,
    output logic              MATCH_ANY
);

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_mar;
    logic [DATA_W-1:0]   r_in;
    logic [OUT_W-1:0]    r_acc;
    logic                r_hit;
    logic [OUT_W-1:0]    r_o;
    logic                r_pub;
    logic                r_done;
    logic                r_match_any;

    logic [EW-1:0]       w_entry;
    logic [DATA_W-1:0]   w_r1;
    logic [DATA_W-1:0]   w_r2;
    logic [OUT_W-1:0]    w_ror;
    logic                w_match;
    logic                w_stop;
    logic                w_pub;
    logic                w_we;
    logic [OUT_W-1:0]    w_acc_nxt;

    assign w_we = WE && (r_state == IDLE);

    ternary_match_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OUT_W  (OUT_W)
    ) u_table (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_we    (w_we),
        .i_waddr (WADDR),
        .i_wdata (WDATA),
        .i_raddr (r_mar),
        .o_rdata (w_entry)
    );

    assign w_r1  = w_entry[EW-1 -: DATA_W];
    assign w_r2  = w_entry[OUT_W +: DATA_W];
    assign w_ror = w_entry[OUT_W-1:0];

    // Each bit: input 1 needs R1, input 0 needs R2 (both set = don't care).
    assign w_match = &((w_r2 & ~r_in) | (w_r1 & r_in) | (w_r1 & w_r2));

    assign w_stop = (r_mar == AW'(DEPTH-1)) ||
                    ((MODE == MODE_FIRST) && r_hit);

    always_comb begin
        w_acc_nxt = r_acc;
        if (MODE == MODE_FIRST) begin
            if (!r_hit) w_acc_nxt = w_ror;
        end else if (MODE == MODE_COUNT) begin
            if (r_acc != '1) w_acc_nxt = r_acc + OUT_W'(1);
        end else begin
            w_acc_nxt = r_acc | w_ror;
        end
    end

    always_comb begin
        w_next = r_state;
        w_pub  = 1'b0;
        unique case (r_state)
            IDLE: if (START) w_next = INIT;
            INIT: w_next = LOOP;
            LOOP: w_next = END;
            END: begin
                if (!w_stop) begin
                    w_next = LOOP;
                end else if (!START) begin
                    w_next = IDLE;
                    w_pub  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_mar       <= '0;
            r_in        <= '0;
            r_acc       <= '0;
            r_hit       <= 1'b0;
            r_o         <= '0;
            r_pub       <= 1'b0;
            r_done      <= 1'b0;
            r_match_any <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pub   <= w_pub;
            r_done  <= r_pub;
            if (r_state == INIT) begin
                r_in  <= I;
                r_acc <= '0;
                r_hit <= 1'b0;
                r_mar <= '0;
            end
            if (r_state == LOOP && w_match) begin
                r_hit <= 1'b1;
                r_acc <= w_acc_nxt;
            end
            if (r_state == END && !w_stop) begin
                r_mar <= r_mar + AW'(1);
            end
            if (w_pub) begin
                r_o         <= r_acc;
                r_match_any <= r_hit;
            end
        end
    end

    assign O         = r_o;
    assign BUSY      = (r_state != IDLE);
    assign DONE      = r_done;
    assign MATCH_ANY = r_match_any;

endmodule

// File: tb/tb_ternary_match_scanner.sv
// Directed bench: three scanners (OR, first-match, count)
// share one stimulus stream.
module tb_ternary_match_scanner;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  I;
    logic        WE;
    logic [2:0]  WADDR;
    logic [19:0] WDATA;

    logic [3:0] o0, o1, o2;
    logic       b0, b1, b2;
    logic       d0, d1, d2;
    logic       m0, m1, m2;

    int errs   = 0;
    int checks = 0;
    int e      = 0;

    always #5 CLOCK = ~CLOCK;

    ternary_match_scanner #(.MODE(0)) u_or (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .I(I),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .O(o0), .BUSY(b0), .DONE(d0), .MATCH_ANY(m0)
    );

    ternary_match_scanner #(.MODE(1)) u_first (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .I(I),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .O(o1), .BUSY(b1), .DONE(d1), .MATCH_ANY(m1)
    );

    ternary_match_scanner #(.MODE(2)) u_cnt (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .I(I),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .O(o2), .BUSY(b2), .DONE(d2), .MATCH_ANY(m2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
        e++;
    endtask

    task automatic to_edge(input int n);
        while (e < n) tick();
    endtask

    // The edge that samples START high is edge 0.
    task automatic go(input logic [7:0] din, input bit hold);
        I     = din;
        START = 1'b1;
        @(posedge CLOCK);
        #1;
        e = 0;
        if (!hold) START = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        WE    = 1'b0;
        I     = 8'h00;
        WADDR = '0;
        WDATA = '0;
        #12;
        chk("rst_O",    32'(o0), 32'h0);
        chk("rst_BUSY", 32'(b0), 32'h0);
        chk("rst_DONE", 32'(d0), 32'h0);
        chk("rst_MANY", 32'(m0), 32'h0);
        RESET = 1'b0;
        tick();

        // I=00: entries 2 and 7 match
        go(8'h00, 1'b0);
        chk("A_busy_e0", 32'(b0), 32'h1);
        to_edge(6);
        chk("A_first_e6", 32'(o1), 32'h0);
        to_edge(7);
        chk("A_first_e7", 32'(o1), 32'hF);
        chk("A_first_idle", 32'(b1), 32'h0);
        to_edge(16);
        chk("A_busy_e16", 32'(b0), 32'h1);
        to_edge(17);
        chk("A_or_O", 32'(o0), 32'hF);
        chk("A_or_many", 32'(m0), 32'h1);
        chk("A_busy_e17", 32'(b0), 32'h0);
        chk("A_done_e17", 32'(d0), 32'h0);
        chk("A_cnt_O", 32'(o2), 32'h2);
        to_edge(18);
        chk("A_done_e18", 32'(d0), 32'h1);
        to_edge(19);
        chk("A_done_e19", 32'(d0), 32'h0);

        // I=FF: entries 3, 4, 5 match
        go(8'hFF, 1'b0);
        to_edge(8);
        chk("C_first_e8", 32'(o1), 32'hF);
        to_edge(9);
        chk("C_first_e9", 32'(o1), 32'hA);
        chk("C_first_done9", 32'(d1), 32'h0);
        to_edge(10);
        chk("C_first_done10", 32'(d1), 32'h1);
        to_edge(17);
        chk("C_or_O", 32'(o0), 32'hE);
        chk("C_cnt_O", 32'(o2), 32'h3);
        to_edge(19);

        // Mid-run write attempt and late I change must not matter
        go(8'h00, 1'b0);
        to_edge(1);
        I = 8'hFF;
        to_edge(2);
        WE    = 1'b1;
        WADDR = 3'd2;
        WDATA = 20'h00000;
        to_edge(5);
        WE = 1'b0;
        to_edge(17);
        chk("W_or_O", 32'(o0), 32'hF);
        chk("W_cnt_O", 32'(o2), 32'h2);
        chk("W_first_O", 32'(o1), 32'hF);
        to_edge(19);

        // START held: stays in END until released
        go(8'hFF, 1'b1);
        to_edge(17);
        chk("H_or_e17", 32'(o0), 32'hF);
        chk("H_busy_e17", 32'(b0), 32'h1);
        to_edge(30);
        chk("H_or_e30", 32'(o0), 32'hF);
        chk("H_first_e30", 32'(o1), 32'hF);
        chk("H_busy_e30", 32'(b0), 32'h1);
        START = 1'b0;
        to_edge(31);
        chk("H_or_e31", 32'(o0), 32'hE);
        chk("H_first_e31", 32'(o1), 32'hA);
        chk("H_cnt_e31", 32'(o2), 32'h3);
        chk("H_busy_e31", 32'(b0), 32'h0);
        to_edge(32);
        chk("H_done_e32", 32'(d0), 32'h1);

        // Write entry 0 = {FF,FF,1} while idle
        WE    = 1'b1;
        WADDR = 3'd0;
        WDATA = 20'hFFFF1;
        tick();
        WE = 1'b0;
        go(8'h00, 1'b0);
        to_edge(3);
        chk("D_first_e3", 32'(o1), 32'h1);
        to_edge(17);
        chk("D_cnt_O", 32'(o2), 32'h3);
        chk("D_or_O", 32'(o0), 32'hF);
        to_edge(19);

        // Asynchronous reset mid-run
        go(8'h00, 1'b0);
        to_edge(6);
        RESET = 1'b1;
        #1;
        chk("R_or_O", 32'(o0), 32'h0);
        chk("R_busy", 32'(b0), 32'h0);
        chk("R_done", 32'(d0), 32'h0);
        chk("R_many", 32'(m0), 32'h0);
        chk("R_first_O", 32'(o1), 32'h0);
        chk("R_cnt_O", 32'(o2), 32'h0);
        #3;
        RESET = 1'b0;
        tick();

        // Entry 0 restored to default
        go(8'h00, 1'b0);
        to_edge(7);
        chk("F_first_O", 32'(o1), 32'hF);
        to_edge(17);
        chk("F_cnt_O", 32'(o2), 32'h2);
        chk("F_or_O", 32'(o0), 32'hF);
        chk("F_or_many", 32'(m0), 32'h1);
        to_edge(19);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ternary_match_scanner.md
Name: ternary_match_scanner

Overview:
- Parametrised successor of the ITC99-style ROM scan controller. It captures an input word and walks a table of DEPTH ternary entries {R1, R2, ROR}, producing one result word per run.
- Generalised in data width, table depth and result width.
- Adds a runtime-writable table, three result modes, and BUSY/DONE/MATCH_ANY status.
- Sits as a leaf FSM in the benchmark-style safety designs.

Parameters:
- DATA_W, 8, width of I and of R1/R2.
- DEPTH, 8, number of table entries (power of two, ≥2); AW = clog2(DEPTH).
- OUT_W, 4, width of ROR and O.
- MODE, 0, result mode: 0 = OR-accumulate, 1 = first-match with early exit, 2 = match count.

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  run request / release.
- I  in  DATA_W  input word, sampled in INIT.
- WE  in  1  table write enable, honoured only in IDLE.
- WADDR  in  AW  table write index.
- WDATA  in  2*DATA_W+OUT_W  entry {R1, R2, ROR}, MSB first.
- O  out  OUT_W  published result.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse in the cycle after O updates.
- MATCH_ANY  out  1  at least one entry matched in the last published run.

Behaviour:
- Reset (async, any state, including mid-run):
  - STATE=IDLE; MAR=0; IN_R=0; ACC=0; HIT=0.
  - O=0, DONE=0, MATCH_ANY=0.
  - Table reloads its default contents from the package.
- Match rule for entry k: ((R2 & ~IN_R) | (R1 & IN_R) | (R1 & R2)) equals all-ones.
  - Per bit: IN=1 needs R1=1; IN=0 needs R2=1.
- FSM (all transitions on CLOCK rising edge):
  - IDLE:
    - START=1 → INIT.
    - WE=1 writes table[WADDR]=WDATA in the same edge; a write and START in the same cycle both take effect.
  - INIT: IN_R←I; ACC←0; HIT←0; MAR←0 → LOOP.
  - LOOP: evaluate entry MAR. On a match, HIT←1 and:
    - MODE0: ACC←ACC | ROR.
    - MODE1: ACC←ROR, only if HIT was 0.
    - MODE2: ACC←ACC+1, saturating at 2^OUT_W−1.
    - Always → END.
  - END:
    - If MAR≠DEPTH−1 and not (MODE1 and HIT): MAR←MAR+1 → LOOP.
    - Otherwise, if START=0: O←ACC; MATCH_ANY←HIT; DONE←1 next cycle → IDLE.
    - Otherwise (START still high): hold in END, O unchanged.
- Latency, counting the edge that samples START as edge 0:
  - Entry k is evaluated at edge 2+2k.
  - The full scan publishes at edge 2·DEPTH+1 (edge 17 for defaults), provided START is low then.
  - MODE1 with the first match at entry k publishes at edge 3+2k.
- WE outside IDLE is ignored; the table is not modified mid-run.
- I changes after INIT have no effect on the run.
- O holds its last value between runs. DONE is 0 except for the single pulse.
- Arithmetic:
  - MAR increments never wrap within a run.
  - The MODE2 counter is OUT_W bits wide and saturates.
  - MODE is elaboration-time only.

Decomposition:
- Package ternary_match_pkg holds:
  - the state enum {IDLE, INIT, LOOP, END};
  - mode constants MODE_OR, MODE_FIRST, MODE_COUNT;
  - function default_entry(k).
- default_entry(k) returns the legacy 8×20-bit table when DATA_W=8, OUT_W=4, DEPTH=8, and zero otherwise.
- Legacy table entries {R1, R2, ROR}:
  - 0: 7F 97 A
  - 1: 39 D6 2
  - 2: A8 FF F
  - 3: FF 6B A
  - 4: FF F6 E
  - 5: FF BA 8
  - 6: CA 75 B
  - 7: 2F FF 4
- One sub-module, ternary_match_table: DEPTH-entry register file with async reset to default_entry, one write port, and one combinational read port.

Test Plan:
- MODE0 default table, I=0x00, START pulsed one cycle → entries 2 and 7 match; O=0xF, MATCH_ANY=1; DONE pulse at edge 18; BUSY high for edges 1–17.
- MODE0, I=0xFF → entries 3, 4, 5 match; O=0xE. Repeat with START held high through edge 30 → FSM stays in END, O keeps its prior value (0xF); publishes 0xE one edge after START drops.
- MODE1, I=0xFF → O=0xA, published at edge 9 (early exit after entry 3). MODE1, I=0x00 → O=0xF at edge 7.
- MODE2, I=0x00 → O=2. Then in IDLE write WADDR=0, WDATA={FF,FF,1} and rerun I=0x00 → O=3.
- WE asserted during LOOP with WADDR=2, WDATA=0 → ignored; MODE0 I=0x00 still gives O=0xF.
- RESET asserted asynchronously at edge 6 of a run → O=0, BUSY=0, DONE=0, MATCH_ANY=0 immediately; previously written entry 0 is restored to {7F,97,A}; next run behaves as from power-up.
